// File: rtl/sort_frame_loader_pkg.sv
// Shared widths, pad value and FSM encoding for the sorter frame loader.
package sort_frame_loader_pkg;
    localparam int W  = 32;
    localparam int N  = 8;
    localparam int IW = $clog2(N);
    localparam logic [W-1:0] PAD_VALUE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        CLR  = 2'd1,
        ARM  = 2'd2,
        WAIT = 2'd3
    } state_e;
endpackage

// File: rtl/sort_frame_loader.sv
// Streams words into an 8-slot frame, pads short frames, then re-arms,
// starts and waits on the downstream 8-entry sorter.
module sort_frame_loader
    import sort_frame_loader_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic [W-1:0] d0,
    output logic [W-1:0] d1,
    output logic [W-1:0] d2,
    output logic [W-1:0] d3,
    output logic [W-1:0] d4,
    output logic [W-1:0] d5,
    output logic [W-1:0] d6,
    output logic [W-1:0] d7,
    output logic         sort_rst,
    output logic         sort_start,
    input  logic         sort_done,
    output logic [3:0]   frame_len,
    output logic         busy
);
    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q;
    logic [N-1:0][W-1:0]   slot_q;
    logic [3:0]            frame_len_q;
    logic                  sort_rst_q, sort_start_q;
    logic                  xfer, frame_end;

    assign s_ready   = (state_q == FILL);
    assign busy      = (state_q != FILL);
    assign xfer      = s_valid && s_ready;
    assign frame_end = xfer && ((idx_q == IW'(N - 1)) || s_last);

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (frame_end) state_d = CLR;
            CLR:     state_d = ARM;
            ARM:     state_d = WAIT;
            WAIT:    if (sort_done) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Pulses are registered off the next state so each lines up with its state cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            sort_rst_q   <= 1'b0;
            sort_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sort_rst_q   <= (state_d == CLR);
            sort_start_q <= (state_d == ARM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            slot_q      <= '0;
            frame_len_q <= '0;
        end else if (xfer) begin
            slot_q[idx_q] <= s_data;
            idx_q         <= idx_q + 1'b1;
            if (frame_end) begin
                frame_len_q <= {1'b0, idx_q} + 4'd1;
                // Unused slots get the unsigned max so they sort to the top.
                for (int i = 0; i < N; i++)
                    if (IW'(i) > idx_q) slot_q[i] <= PAD_VALUE;
            end
        end else if (state_q == WAIT && sort_done) begin
            idx_q <= '0;
        end
    end

    assign sort_rst   = sort_rst_q;
    assign sort_start = sort_start_q;
    assign frame_len  = frame_len_q;
    assign d0 = slot_q[0];
    assign d1 = slot_q[1];
    assign d2 = slot_q[2];
    assign d3 = slot_q[3];
    assign d4 = slot_q[4];
    assign d5 = slot_q[5];
    assign d6 = slot_q[6];
    assign d7 = slot_q[7];
endmodule

// File: doc/sort_frame_loader.md
Name: sort_frame_loader

Overview:
- Upstream feeder for the 8-entry quicksort stage.
- Collects a serial stream of 32-bit words (valid/ready, with last) into an 8-word frame and pads short frames with a fill value.
- Re-arms the sorter, pulses its start, then waits for its done before accepting the next frame.
- The re-arm is needed because the sorter accepts only one start per reset.

Parameters:
- W, 32, data word width; must match the sorter.
- N, 8, frame depth; fixed at 8 to match the sorter's port count.
- PAD_VALUE, 32'hFFFF_FFFF, fill for unused slots. It is the unsigned maximum, so pads sort to the top slots.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_data  in  W  stream word
- s_valid  in  1  s_data valid
- s_last  in  1  final word of frame, qualified by s_valid
- s_ready  out  1  loader can accept a word
- d0..d7  out  W each  frame slots, driving sorter in0..in7
- sort_rst  out  1  active-high, one-cycle re-arm pulse to sorter rst
- sort_start  out  1  one-cycle start pulse to sorter start
- sort_done  in  1  sorter done level
- frame_len  out  4  real (non-pad) word count of the current frame, 1..8
- busy  out  1  high whenever state is not FILL

Behaviour:
- Reset (async, rst_n=0) values:
  - state=FILL, idx=0.
  - s_ready=1, d0..d7=0, sort_rst=0, sort_start=0, frame_len=0, busy=0.
  - A reset mid-frame discards partial data.
- Handshake: a word transfers on a rising edge with s_valid&&s_ready. s_ready is high only in FILL (combinational from state).
- States and transitions:
  - FILL: on transfer, d[idx]<=s_data and idx<=idx+1.
    - If idx==N-1 or s_last, go to CLR and set frame_len<=idx+1.
    - In the same edge, every slot above idx gets PAD_VALUE.
    - s_last on the 8th word behaves the same as a full frame. s_last is ignored when s_valid=0.
  - CLR: sort_rst=1 for exactly one cycle. Next state is ARM.
  - ARM: sort_rst=0, sort_start=1 for exactly one cycle. Next state is WAIT.
  - WAIT: hold d0..d7 stable. When sort_done==1, go to FILL with idx<=0; s_ready rises the next cycle.
- sort_rst and sort_start are registered outputs; they are never high together.
- Latency: last accepted word at edge T → sort_rst high in cycle T+1 → sort_start high in cycle T+2 → WAIT from T+3.
- Stale done: sort_done is sampled only in WAIT. Any done left over from a previous frame is cleared by sort_rst in CLR, so it cannot end WAIT early.
- No timeout: WAIT persists until sort_done arrives. Only rst_n aborts it.
- d0..d7 change only in FILL.
- frame_len holds its value through CLR, ARM and WAIT, and until the next frame's final word.
- Width rules:
  - idx is 3 bits; it never wraps within a frame because the transition occurs at idx==7.
  - frame_len = idx+1, computed in 4 bits.
- An empty frame is impossible: s_last counts only with a transfer, so the minimum frame_len is 1.

Decomposition:
- Shared package holds W, N, PAD_VALUE, and the state encoding: FILL=2'd0, CLR=2'd1, ARM=2'd2, WAIT=2'd3.
- No sub-module; a single FSM with a slot register file.

Test Plan:
- Full frame: 8 back-to-back words 8,3,7,1,6,2,5,4 with s_last on the 8th.
  - d0..d7 = 8,3,7,1,6,2,5,4; frame_len=8.
  - sort_rst one cycle after the last transfer, sort_start the cycle after; s_ready=0 until sort_done.
  - Sorter outputs 1..8.
- Short frame: 3 words 30,10,20 with s_last on the 3rd.
  - d0..d2 = 30,10,20; d3..d7 = FFFF_FFFF; frame_len=3.
  - Sorter outputs 10,20,30 then five FFFF_FFFF.
- Back-to-back frames: a second frame 5,4,3,2,1,0,9,8 streamed right after the first frame's done.
  - The sorter is re-armed via sort_rst and the second sorted result is 0,1,2,3,4,5,8,9.
  - The first frame's stale done does not end the second frame's WAIT.
- Backpressure/gaps: s_valid toggled randomly; s_valid held during WAIT.
  - No word is accepted in CLR/ARM/WAIT; no words are lost or duplicated.
  - s_last with s_valid=0 has no effect.
- Reset mid-operation: rst_n low after 5 words, and again during WAIT.
  - Immediately s_ready=1, sort_start=0, idx=0, d*=0.
  - The next frame loads from slot 0.
- Sorter hang: sort_done held at 0.
  - Loader stays in WAIT with busy=1, s_ready=0 and outputs stable indefinitely.
